// File: rtl/stall_pipe_pkg.sv
// Shared constants for the stalling three-stage register pipeline.
package stall_pipe_pkg;

    localparam int STAGES              = 3;
    localparam int STALL_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: a data register plus valid bit, advancing only when downstream can take it.
module pipe_stage_reg #(
    parameter int WIDTH = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    input  logic             flush,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    // A stage can take a new item when empty or when its current item moves on.
    assign ready = ~valid | down_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (ready) begin
                valid <= up_valid;
            end
            if (ready && up_valid && !flush) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/stall_pipeline_ctrl.sv
// Three-stage valid/ready pipeline with bubble collapse, flush, occupancy and a saturating stall counter.
module stall_pipeline_ctrl
    import stall_pipe_pkg::*;
#(
    parameter int WIDTH       = 100,
    parameter int STALL_CNT_W = STALL_CNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       datain,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       dataout,
    input  logic                   flush,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

    logic             vld_p  [0:STAGES];
    logic [WIDTH-1:0] data_p [0:STAGES];
    logic             rdy_p  [1:STAGES+1];

    assign vld_p[0]         = in_valid & ~flush;
    assign data_p[0]        = datain;
    assign rdy_p[STAGES+1]  = out_ready;

    // ---- stage chain: index 1 is the input stage, STAGES drives the output ----
    for (genvar i = 1; i <= STAGES; i++) begin : g_stage
        pipe_stage_reg #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (vld_p[i-1]),
            .up_data    (data_p[i-1]),
            .down_ready (rdy_p[i+1]),
            .flush      (flush),
            .valid      (vld_p[i]),
            .data       (data_p[i]),
            .ready      (rdy_p[i])
        );
    end

    assign in_ready  = rdy_p[1] & ~flush;
    assign out_valid = vld_p[STAGES];
    assign dataout   = data_p[STAGES];

    always_comb begin
        occupancy = '0;
        for (int i = 1; i <= STAGES; i++) begin
            occupancy = occupancy + {1'b0, vld_p[i]};
        end
    end

    // ---- debug: cycles the consumer held off a valid output; only reset clears it ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_stall_pipeline_ctrl.sv
// Scoreboard bench for stall_pipeline_ctrl: item-position reference model plus a decoupled output monitor.
module tb_stall_pipeline_ctrl;

    localparam int W  = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  datain = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  dataout;
    logic          flush = 1'b0;
    logic [1:0]    occupancy;
    logic [SW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    stall_pipeline_ctrl #(
        .WIDTH       (W),
        .STALL_CNT_W (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight items, oldest first, each with its stage position 1..3.
    typedef struct {
        int           pos;
        logic [W-1:0] d;
    } item_t;

    item_t        items[$];
    logic [W-1:0] sb[$];
    int           stall_m = 0;
    int           newpos[3];
    bit           head_leaves;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Where each item will sit after the next edge: an item moves up if the slot ahead ends up free.
    function automatic void plan(input logic r);
        int taken;
        taken       = 4;
        head_leaves = 0;
        for (int k = 0; k < items.size(); k++) begin
            int p;
            p = items[k].pos;
            if (p == 3) begin
                if (r) begin
                    head_leaves = 1;
                    newpos[k]   = 0;
                    taken       = 4;
                end else begin
                    newpos[k] = 3;
                    taken     = 3;
                end
            end else if (taken != p + 1) begin
                newpos[k] = p + 1;
                taken     = p + 1;
            end else begin
                newpos[k] = p;
                taken     = p;
            end
        end
    endfunction

    function automatic bit exp_in_ready(input logic r, input logic f);
        bit free1;
        if (f) return 1'b0;
        plan(r);
        free1 = 1'b1;
        for (int k = 0; k < items.size(); k++)
            if (newpos[k] == 1) free1 = 1'b0;
        return free1;
    endfunction

    function automatic bit exp_out_valid();
        return (items.size() > 0) && (items[0].pos == 3);
    endfunction

    task automatic model_edge();
        bit    acc;
        item_t nq[$];
        acc = in_valid && exp_in_ready(out_ready, flush);
        plan(out_ready);
        if (exp_out_valid() && !out_ready)
            stall_m = (stall_m == 15) ? 15 : stall_m + 1;
        if (flush) begin
            items.delete();
            sb.delete();
        end else begin
            for (int k = 0; k < items.size(); k++) begin
                if (newpos[k] != 0) begin
                    item_t it;
                    it.pos = newpos[k];
                    it.d   = items[k].d;
                    nq.push_back(it);
                end
            end
            if (acc) begin
                item_t it;
                it.pos = 1;
                it.d   = datain;
                nq.push_back(it);
                sb.push_back(datain);
            end
            items = nq;
        end
    endtask

    // Called at posedge+2; drives one cycle of inputs and checks the result of its edge.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        in_valid  = v;
        datain    = d;
        out_ready = r;
        flush     = f;
        #1;
        chk("in_ready", in_ready, exp_in_ready(r, f));
        @(posedge clk);
        model_edge();
        #2;
        chk("out_valid", out_valid, exp_out_valid());
        chk("occupancy", occupancy, items.size());
        chk("stall_cnt", stall_cnt, stall_m);
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_dataout", dataout, 0);
        chk("rst_in_ready", in_ready, 1);
        items.delete();
        sb.delete();
        stall_m   = 0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Monitor: every output handshake must deliver the oldest outstanding accepted item.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", dataout, 0);
                    if (dataout == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %0h expected no item", dataout);
                    end
                end else begin
                    chk("dataout", dataout, sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [W-1:0] a, b, c, d;

        #1 rst = 1'b1;
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_occupancy", occupancy, 0);
        chk("init_stall_cnt", stall_cnt, 0);
        chk("init_in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // streaming
        for (int i = 1; i <= 5; i++) cyc(1'b1, W'(i), 1'b1, 1'b0);
        repeat (5) cyc(1'b0, '0, 1'b1, 1'b0);

        // fill and stall, then release
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        cyc(1'b1, a, 1'b0, 1'b0);
        cyc(1'b1, b, 1'b0, 1'b0);
        cyc(1'b1, c, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, d, 1'b0, 1'b0);
        chk("fill_dataout_held", dataout, a);
        cyc(1'b1, d, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, '0, 1'b1, 1'b0);

        // bubble collapse
        a = $urandom; b = $urandom;
        cyc(1'b1, a, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, b, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("bubble_occupancy", occupancy, 2);
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);

        // async reset with two items in flight
        cyc(1'b1, $urandom, 1'b0, 1'b0);
        cyc(1'b1, $urandom, 1'b0, 1'b0);
        async_reset();

        // flush with three in flight, consumer ready and stalled
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b1, 1'b0);
        cyc(1'b1, $urandom, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        cyc(1'b1, $urandom, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

        // saturation of the 4-bit stall counter
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, '0, 1'b0, 1'b0);
        chk("stall_saturated", stall_cnt, 15);
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) async_reset();
            else cyc(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 20) == 0);
        end

        repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
